// File: rtl/ysyx_22040895_idu_stage_pkg.sv
// Shared decode constants for the registered IDU stage: opcodes, CSR
// addresses and indices, immediate-type encoding and bundle width.
package ysyx_22040895_idu_stage_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM32    = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_REG32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    localparam int unsigned CSR_IDX_MEPC    = 0;
    localparam int unsigned CSR_IDX_MCAUSE  = 1;
    localparam int unsigned CSR_IDX_MTVEC   = 2;
    localparam int unsigned CSR_IDX_MSTATUS = 3;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    // opcode + func3 + func7 + rs1 + rs2 + rd + csr_hit + is_ecall + is_mret
    localparam int unsigned BUNDLE_FIXED_W = 7 + 3 + 7 + 5 + 5 + 5 + 1 + 1 + 1;

    // pc and imm are XLEN wide each, plus the CSR index
    function automatic int unsigned bundle_w(input int unsigned xlen, input int unsigned csr_idx_w);
        return 2 * xlen + csr_idx_w + BUNDLE_FIXED_W;
    endfunction

    function automatic imm_type_e imm_type(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: return IMM_I;
            OP_STORE:                                      return IMM_S;
            OP_BRANCH:                                     return IMM_B;
            OP_LUI, OP_AUIPC:                              return IMM_U;
            OP_JAL:                                        return IMM_J;
            default:                                       return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040895_idu_stage_if.sv
// Handshake and bundle signals between IFU, the IDU stage and EXU.
// master: upstream/downstream environment; slave: the IDU stage.
interface ysyx_22040895_idu_stage_if #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned CSR_IDX_W = 3
);
    logic                 flush_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [31:0]          inst_i;
    logic [XLEN-1:0]      pc_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [XLEN-1:0]      pc_o;
    logic [6:0]           opcode_o;
    logic [2:0]           func3_o;
    logic [6:0]           func7_o;
    logic [4:0]           rs1_o;
    logic [4:0]           rs2_o;
    logic [4:0]           rd_o;
    logic [XLEN-1:0]      imm_o;
    logic [CSR_IDX_W-1:0] csr_idx_o;
    logic                 csr_hit_o;
    logic                 is_ecall_o;
    logic                 is_mret_o;
    logic                 illegal_o;

    modport master (
        output flush_i, in_valid_i, inst_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, opcode_o, func3_o, func7_o,
               rs1_o, rs2_o, rd_o, imm_o, csr_idx_o, csr_hit_o,
               is_ecall_o, is_mret_o, illegal_o
    );

    modport slave (
        input  flush_i, in_valid_i, inst_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, opcode_o, func3_o, func7_o,
               rs1_o, rs2_o, rd_o, imm_o, csr_idx_o, csr_hit_o,
               is_ecall_o, is_mret_o, illegal_o
    );

endinterface

// File: rtl/ysyx_22040895_idu_dec.sv
// Combinational RV instruction decoder: fields, sign-extended immediate,
// CSR index lookup and ecall/mret flags.
// Optional illegal-instruction detection: YSYX_22040895_ILLEGAL_DET_EN.
module ysyx_22040895_idu_dec
    import ysyx_22040895_idu_stage_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned CSR_IDX_W = 3
) (
    input  logic [31:0]          inst_i,
    output logic [6:0]           opcode_o,
    output logic [2:0]           func3_o,
    output logic [6:0]           func7_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [4:0]           rd_o,
    output logic [XLEN-1:0]      imm_o,
    output logic [CSR_IDX_W-1:0] csr_idx_o,
    output logic                 csr_hit_o,
    output logic                 is_ecall_o,
    output logic                 is_mret_o
`ifdef YSYX_22040895_ILLEGAL_DET_EN
    ,
    output logic                 illegal_o
`endif
);

    logic signed [31:0] imm32;

    assign opcode_o   = inst_i[6:0];
    assign rd_o       = inst_i[11:7];
    assign func3_o    = inst_i[14:12];
    assign rs1_o      = inst_i[19:15];
    assign rs2_o      = inst_i[24:20];
    assign func7_o    = inst_i[31:25];
    assign is_ecall_o = (inst_i == INST_ECALL);
    assign is_mret_o  = (inst_i == INST_MRET);

    // Every format fits a sign-extended 32-bit value; widen it to XLEN once.
    assign imm_o = XLEN'(imm32);

    // Immediate formatting selected by opcode class
    always_comb begin
        imm32 = '0;
        case (imm_type(inst_i[6:0]))
            IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U:   imm32 = {inst_i[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // CSR address to internal index; misses map to index 0
    always_comb begin
        csr_idx_o = '0;
        csr_hit_o = 1'b0;
        case (inst_i[31:20])
            CSR_MEPC:    begin csr_idx_o = CSR_IDX_W'(CSR_IDX_MEPC);    csr_hit_o = 1'b1; end
            CSR_MCAUSE:  begin csr_idx_o = CSR_IDX_W'(CSR_IDX_MCAUSE);  csr_hit_o = 1'b1; end
            CSR_MTVEC:   begin csr_idx_o = CSR_IDX_W'(CSR_IDX_MTVEC);   csr_hit_o = 1'b1; end
            CSR_MSTATUS: begin csr_idx_o = CSR_IDX_W'(CSR_IDX_MSTATUS); csr_hit_o = 1'b1; end
            default:     begin csr_idx_o = '0;                          csr_hit_o = 1'b0; end
        endcase
    end

`ifdef YSYX_22040895_ILLEGAL_DET_EN
    // Unknown opcode, non-32-bit encoding, or an unsupported SYSTEM func3=0 form
    always_comb begin
        illegal_o = 1'b0;
        if (inst_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end
        if (!(inst_i[6:0] inside {OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_IMM32, OP_STORE,
                                  OP_REG, OP_LUI, OP_REG32, OP_BRANCH, OP_JALR, OP_JAL,
                                  OP_SYSTEM})) begin
            illegal_o = 1'b1;
        end
        if ((inst_i[6:0] == OP_SYSTEM) && (inst_i[14:12] == 3'b000) &&
            !is_ecall_o && !is_mret_o) begin
            illegal_o = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ysyx_22040895_idu_stage.sv
// Registered IDU stage: decodes the incoming beat and holds it in a main
// register backed by a one-entry skid register (valid/ready, 1-cycle latency).
// Optional illegal-instruction flag: YSYX_22040895_ILLEGAL_DET_EN.
module ysyx_22040895_idu_stage
    import ysyx_22040895_idu_stage_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned CSR_IDX_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22040895_idu_stage_if.slave bus
);

`ifdef YSYX_22040895_ILLEGAL_DET_EN
    localparam int unsigned BW = bundle_w(XLEN, CSR_IDX_W) + 1;
`else
    localparam int unsigned BW = bundle_w(XLEN, CSR_IDX_W);
`endif

    logic [6:0]           dec_opcode;
    logic [2:0]           dec_func3;
    logic [6:0]           dec_func7;
    logic [4:0]           dec_rs1;
    logic [4:0]           dec_rs2;
    logic [4:0]           dec_rd;
    logic [XLEN-1:0]      dec_imm;
    logic [CSR_IDX_W-1:0] dec_csr_idx;
    logic                 dec_csr_hit;
    logic                 dec_ecall;
    logic                 dec_mret;
    logic [BW-1:0]        in_bundle;

    logic                 main_v_q, main_v_d;
    logic                 skid_v_q, skid_v_d;
    logic [BW-1:0]        main_q, main_d;
    logic [BW-1:0]        skid_q, skid_d;
    logic                 accept;
    logic                 drain;

`ifdef YSYX_22040895_ILLEGAL_DET_EN
    logic                 dec_illegal;
`endif

    ysyx_22040895_idu_dec #(
        .XLEN      (XLEN),
        .CSR_IDX_W (CSR_IDX_W)
    ) u_dec (
        .inst_i     (bus.inst_i),
        .opcode_o   (dec_opcode),
        .func3_o    (dec_func3),
        .func7_o    (dec_func7),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2),
        .rd_o       (dec_rd),
        .imm_o      (dec_imm),
        .csr_idx_o  (dec_csr_idx),
        .csr_hit_o  (dec_csr_hit),
        .is_ecall_o (dec_ecall),
        .is_mret_o  (dec_mret)
`ifdef YSYX_22040895_ILLEGAL_DET_EN
        ,
        .illegal_o  (dec_illegal)
`endif
    );

`ifdef YSYX_22040895_ILLEGAL_DET_EN
    assign in_bundle = {dec_illegal, bus.pc_i, dec_opcode, dec_func3, dec_func7, dec_rs1,
                        dec_rs2, dec_rd, dec_imm, dec_csr_idx, dec_csr_hit, dec_ecall, dec_mret};
    assign {bus.illegal_o, bus.pc_o, bus.opcode_o, bus.func3_o, bus.func7_o, bus.rs1_o,
            bus.rs2_o, bus.rd_o, bus.imm_o, bus.csr_idx_o, bus.csr_hit_o, bus.is_ecall_o,
            bus.is_mret_o} = main_q;
`else
    assign in_bundle = {bus.pc_i, dec_opcode, dec_func3, dec_func7, dec_rs1,
                        dec_rs2, dec_rd, dec_imm, dec_csr_idx, dec_csr_hit, dec_ecall, dec_mret};
    assign {bus.pc_o, bus.opcode_o, bus.func3_o, bus.func7_o, bus.rs1_o,
            bus.rs2_o, bus.rd_o, bus.imm_o, bus.csr_idx_o, bus.csr_hit_o, bus.is_ecall_o,
            bus.is_mret_o} = main_q;
    assign bus.illegal_o = 1'b0;
`endif

    // Ready depends only on the registered skid state
    assign bus.in_ready_o  = !skid_v_q;
    assign bus.out_valid_o = main_v_q;
    assign accept          = bus.in_valid_i && !skid_v_q;
    assign drain           = main_v_q && bus.out_ready_i;

    // Next-state for main/skid: flush first, then skid refill, then direct load, then stall capture
    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (bus.flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (drain && skid_v_q) begin
            // accept is impossible here since in_ready is low while skid is full
            main_d   = skid_q;
            main_v_d = 1'b1;
            skid_v_d = 1'b0;
        end else if (accept && (!main_v_q || drain)) begin
            main_d   = in_bundle;
            main_v_d = 1'b1;
        end else if (accept) begin
            skid_d   = in_bundle;
            skid_v_d = 1'b1;
        end else if (drain) begin
            main_v_d = 1'b0;
        end
    end

    // Bundle and valid registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

endmodule
